// File: rtl/press_classifier.sv
// Classifies debounced presses as short or long. Emits one-cycle event pulses,
// a held flag for ongoing long presses, and a saturating press count.
module press_classifier #(
  parameter int LONG_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             count_clr,
  output logic             short_pulse,
  output logic             long_pulse,
  output logic             held,
  output logic [CNT_W-1:0] press_count
);

  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
  logic             short_pulse_q, short_pulse_d;
  logic             long_pulse_q, long_pulse_d;
  logic             held_q, held_d;
  logic [CNT_W-1:0] press_count_q, press_count_d;
  logic             count_inc;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = '0;
    short_pulse_d = 1'b0;
    long_pulse_d  = 1'b0;
    count_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in) begin
          state_d    = PRESS;
          hold_cnt_d = HW'(1);
        end
      end
      PRESS: begin
        if (!in) begin
          state_d       = IDLE;
          short_pulse_d = 1'b1;
          count_inc     = 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d      = LONG;
          long_pulse_d = 1'b1;
          count_inc    = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      LONG: begin
        if (!in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    held_d = (state_d == LONG);

    // Clear takes priority over a same-cycle increment.
    if (count_clr)
      press_count_d = '0;
    else if (count_inc && press_count_q != CNT_MAX)
      press_count_d = press_count_q + 1'b1;
    else
      press_count_d = press_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      short_pulse_q <= 1'b0;
      long_pulse_q  <= 1'b0;
      held_q        <= 1'b0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      short_pulse_q <= short_pulse_d;
      long_pulse_q  <= long_pulse_d;
      held_q        <= held_d;
      press_count_q <= press_count_d;
    end
  end

  assign short_pulse = short_pulse_q;
  assign long_pulse  = long_pulse_q;
  assign held        = held_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier: a run-length reference model predicts
// each cycle's outputs; a monitor compares them after every clock edge.
module tb_press_classifier;

  localparam int L  = 16;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in = 1'b0;
  logic          count_clr = 1'b0;
  logic          short_pulse, long_pulse, held;
  logic [CW-1:0] press_count;

  press_classifier #(.LONG_CYCLES(L), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .count_clr   (count_clr),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .held        (held),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          s;
    logic          l;
    logic          h;
    logic [CW-1:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model: length of the current run of 1 samples, and the count.
  int ones = 0;
  int cnt  = 0;

  task automatic step(input logic i, input logic clr, input logic rst);
    exp_t e;
    logic ev;
    reset = rst; in = i; count_clr = clr;
    e  = '0;
    ev = 1'b0;
    if (rst) begin
      ones = 0;
      cnt  = 0;
    end else begin
      if (i) begin
        ones = ones + 1;
        e.l  = (ones == L);
        e.h  = (ones >= L);
        ev   = e.l;
      end else begin
        e.s  = (ones >= 1) && (ones < L);
        ev   = e.s;
        ones = 0;
      end
      if (clr) cnt = 0;
      else if (ev && cnt < CMAX) cnt = cnt + 1;
    end
    e.c = cnt[CW-1:0];
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input logic i, input int n);
    for (int k = 0; k < n; k++) step(i, 1'b0, 1'b0);
  endtask

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("short_pulse", int'(short_pulse), int'(e.s));
      cmp("long_pulse",  int'(long_pulse),  int'(e.l));
      cmp("held",        int'(held),        int'(e.h));
      cmp("press_count", int'(press_count), int'(e.c));
      if (e.s || e.l)
        $display("press event: short=%0d long=%0d count=%0d t=%0t", e.s, e.l, e.c, $time);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    // Reset with in high, then idle.
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    run(1'b0, 5);
    // Short press of 5, then the 15/16 boundary.
    run(1'b1, 5);  run(1'b0, 2);
    run(1'b1, 15); run(1'b0, 1);
    run(1'b1, 16); run(1'b1, 3); run(1'b0, 2);
    // Saturation then clear on the cycle a 6th press ends.
    step(1'b0, 1'b1, 1'b0);
    for (int p = 0; p < 5; p++) begin
      run(1'b1, 2); run(1'b0, 1);
    end
    run(1'b1, 3);
    step(1'b0, 1'b1, 1'b0);
    run(1'b0, 2);
    // Reset mid-long, release with in still high.
    run(1'b1, 20);
    step(1'b1, 1'b0, 1'b1);
    run(1'b1, 18); run(1'b0, 2);
    // Back-to-back presses 1,1,0,1,1,0.
    run(1'b1, 2); run(1'b0, 1); run(1'b1, 2); run(1'b0, 3);
    // Randomized presses with sporadic clears and resets.
    for (int p = 0; p < 150; p++) begin
      int n;
      n = $urandom_range(1, 22);
      for (int k = 0; k < n; k++)
        step(1'b1, ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++)
        step(1'b0, ($urandom_range(0, 15) == 0), 1'b0);
    end
    run(1'b0, 3);
    @(negedge clk);
    cmp("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
